// File: rtl/mips_enc_pkg.sv
// Shared types and constants for the MIPS program-loader encoder.
// Holds the command kind enum, the loader FSM states, the opcode/funct
// constants (shared with the control decoder) and field-packing helpers.
package mips_enc_pkg;

  typedef enum logic [3:0] {
    KIND_ADD  = 4'd0,
    KIND_SUB  = 4'd1,
    KIND_AND  = 4'd2,
    KIND_OR   = 4'd3,
    KIND_NOR  = 4'd4,
    KIND_SLL  = 4'd5,
    KIND_SRL  = 4'd6,
    KIND_ADDI = 4'd7,
    KIND_ORI  = 4'd8,
    KIND_ANDI = 4'd9,
    KIND_LUI  = 4'd10,
    KIND_BEQ  = 4'd11,
    KIND_BNE  = 4'd12,
    KIND_J    = 4'd13,
    KIND_JAL  = 4'd14,
    KIND_RSVD = 4'd15
  } kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;

  // R-type: op | rs | rt | rd | shamt | funct
  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] shamt,
                                        input logic [5:0] funct);
    return {OP_RTYPE, rs, rt, rd, shamt, funct};
  endfunction

  // I-type: op | rs | rt | imm
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  // J-type: op | word target
  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

endpackage

// File: rtl/mips_instr_fmt.sv
// Combinational formatter: instruction kind + operand fields -> 32-bit MIPS word.
// Ports: i_kind/i_rs/i_rt/i_rd/i_shamt/i_imm/i_tgt operand inputs;
//        o_word_c encoded word, o_illegal_c set for the reserved kind (word is NOP).
module mips_instr_fmt
  import mips_enc_pkg::*;
(
  input  kind_e       i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_shamt,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_tgt,
  output logic [31:0] o_word_c,
  output logic        o_illegal_c
);

  // Non-shift R-types carry shamt=0; shifts carry rs=0; LUI carries rs=0.
  always_comb begin
    o_word_c    = 32'h0000_0000;
    o_illegal_c = 1'b0;
    case (i_kind)
      KIND_ADD:  o_word_c = enc_r(i_rs, i_rt, i_rd, 5'd0, FUNCT_ADD);
      KIND_SUB:  o_word_c = enc_r(i_rs, i_rt, i_rd, 5'd0, FUNCT_SUB);
      KIND_AND:  o_word_c = enc_r(i_rs, i_rt, i_rd, 5'd0, FUNCT_AND);
      KIND_OR:   o_word_c = enc_r(i_rs, i_rt, i_rd, 5'd0, FUNCT_OR);
      KIND_NOR:  o_word_c = enc_r(i_rs, i_rt, i_rd, 5'd0, FUNCT_NOR);
      KIND_SLL:  o_word_c = enc_r(5'd0, i_rt, i_rd, i_shamt, FUNCT_SLL);
      KIND_SRL:  o_word_c = enc_r(5'd0, i_rt, i_rd, i_shamt, FUNCT_SRL);
      KIND_ADDI: o_word_c = enc_i(OP_ADDI, i_rs, i_rt, i_imm);
      KIND_ORI:  o_word_c = enc_i(OP_ORI, i_rs, i_rt, i_imm);
      KIND_ANDI: o_word_c = enc_i(OP_ANDI, i_rs, i_rt, i_imm);
      KIND_LUI:  o_word_c = enc_i(OP_LUI, 5'd0, i_rt, i_imm);
      KIND_BEQ:  o_word_c = enc_i(OP_BEQ, i_rs, i_rt, i_imm);
      KIND_BNE:  o_word_c = enc_i(OP_BNE, i_rs, i_rt, i_imm);
      KIND_J:    o_word_c = enc_j(OP_J, i_tgt);
      KIND_JAL:  o_word_c = enc_j(OP_JAL, i_tgt);
      default:   o_illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Program-loader encoder: accepts symbolic instruction commands over valid/ready,
// encodes each to a MIPS word and writes it sequentially into instruction memory.
// Ports: clk, reset (async active-low); start begins a session at word 0;
//        in_valid/in_ready/in_last command handshake with in_kind and operand fields;
//        mem_we/mem_addr/mem_wdata memory write port; done, full, err (sticky), count.
// Build option: define ENC_BRANCH_REL_EN to treat BEQ/BNE in_imm as an absolute
// destination word index converted to a PC-relative offset.
module mips_instr_encoder
  import mips_enc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0040_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [31:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam int unsigned       CNT_W    = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  state_e              r_state;
  logic [ADDR_W-1:0]   r_idx;
  logic                r_in_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_done;
  logic                r_full;
  logic                r_err;
  logic [CNT_W-1:0]    r_count;

  kind_e               w_kind;
  logic [15:0]         w_imm;
  logic [31:0]         w_word;
  logic                w_illegal;
  logic                w_jbad;
  logic                w_accept;
  logic                w_at_end;
  logic                w_unused_tgt;

  assign w_kind       = kind_e'(in_kind);
  assign w_accept     = in_valid & r_in_ready;
  assign w_at_end     = (r_idx == LAST_IDX);
  assign w_unused_tgt = ^in_target[1:0];

  // Jumps can only reach the 256 MB region that holds the program image.
  assign w_jbad = ((w_kind == KIND_J) || (w_kind == KIND_JAL)) &&
                  (in_target[31:28] != BASE_ADDR[31:28]);

`ifdef ENC_BRANCH_REL_EN
  // Branch offset is relative to the delay-slot address (index + 1).
  assign w_imm = ((w_kind == KIND_BEQ) || (w_kind == KIND_BNE))
               ? (in_imm - (16'(r_idx) + 16'd1))
               : in_imm;
`else
  assign w_imm = in_imm;
`endif

  mips_instr_fmt u_fmt (
    .i_kind      (w_kind),
    .i_rs        (in_rs),
    .i_rt        (in_rt),
    .i_rd        (in_rd),
    .i_shamt     (in_shamt),
    .i_imm       (w_imm),
    .i_tgt       (in_target[27:2]),
    .o_word_c    (w_word),
    .o_illegal_c (w_illegal)
  );

  // Session FSM, write index and registered write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'h0000_0000;
      r_done      <= 1'b0;
      r_full      <= 1'b0;
      r_err       <= 1'b0;
      r_count     <= '0;
    end else begin
      r_mem_we <= 1'b0;
      if (start) begin
        // Fresh session from any state; a same-cycle accept is dropped.
        r_state    <= ST_LOAD;
        r_idx      <= '0;
        r_in_ready <= 1'b1;
        r_done     <= 1'b0;
        r_full     <= 1'b0;
        r_err      <= 1'b0;
        r_count    <= '0;
      end else begin
        case (r_state)
          ST_LOAD: begin
            if (w_accept) begin
              r_mem_we    <= 1'b1;
              r_mem_addr  <= r_idx;
              r_mem_wdata <= w_word;
              r_idx       <= r_idx + ADDR_W'(1);
              r_count     <= r_count + CNT_W'(1);
              if (w_illegal || w_jbad) r_err <= 1'b1;
              if (w_at_end) r_full <= 1'b1;
              if (in_last || w_at_end) begin
                r_state    <= ST_DONE;
                r_done     <= 1'b1;
                r_in_ready <= 1'b0;
              end
            end
          end
          ST_IDLE, ST_DONE: r_in_ready <= 1'b0;
          default: begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign done      = r_done;
  assign full      = r_full;
  assign err       = r_err;
  assign count     = r_count;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Directed bench for mips_instr_encoder with a 4-word memory (ADDR_W=2).
module tb_mips_instr_encoder;

  localparam int unsigned ADDR_W = 2;

  logic              clk;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [3:0]        in_kind;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_rd;
  logic [4:0]        in_shamt;
  logic [15:0]       in_imm;
  logic [31:0]       in_target;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              done;
  logic              full;
  logic              err;
  logic [ADDR_W:0]   count;

  int checks = 0;
  int errors = 0;

  mips_instr_encoder #(.ADDR_W(ADDR_W), .BASE_ADDR(32'h0040_0000)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_kind   (in_kind),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_rd     (in_rd),
    .in_shamt  (in_shamt),
    .in_imm    (in_imm),
    .in_target (in_target),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .done      (done),
    .full      (full),
    .err       (err),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [3:0] k, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                     input logic [31:0] tgt, input logic last);
    in_valid  = 1'b1;
    in_kind   = k;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_shamt  = sh;
    in_imm    = imm;
    in_target = tgt;
    in_last   = last;
  endtask

  task automatic idle_in();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [31:0] exp_beq;

  initial begin
`ifdef ENC_BRANCH_REL_EN
    exp_beq = 32'h1022_0002;
`else
    exp_beq = 32'h1022_0005;
`endif
    reset = 1'b0; start = 1'b0;
    idle_in();
    in_kind = 4'd0; in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0;
    in_imm = '0; in_target = '0;
    tick(); tick();
    reset = 1'b1;
    tick();

    // Reset values
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we",    32'(mem_we),   32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata,     32'd0);
    chk("rst_flags", {28'd0, done, full, err, 1'b0}, 32'd0);
    chk("rst_count", 32'(count),    32'd0);

    // ADD rd=3 rs=1 rt=2 at index 0 (shamt forced to 0)
    do_start();
    chk("ld_ready", 32'(in_ready), 32'd1);
    cmd(4'd0, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 32'h0, 1'b0);
    tick();
    idle_in();
    chk("add_we",    32'(mem_we),   32'd1);
    chk("add_addr",  32'(mem_addr), 32'd0);
    chk("add_wdata", mem_wdata,     32'h0022_1820);
    chk("add_count", 32'(count),    32'd1);
    tick();
    chk("add_we_off", 32'(mem_we), 32'd0);

    // Back-to-back ADDI then LUI (last)
    do_start();
    chk("b2b_cnt0", 32'(count), 32'd0);
    cmd(4'd7, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 32'h0, 1'b0);
    tick();
    chk("addi_addr",  32'(mem_addr), 32'd0);
    chk("addi_wdata", mem_wdata,     32'h2008_0005);
    chk("addi_done",  32'(done),     32'd0);
    cmd(4'd10, 5'd9, 5'd1, 5'd0, 5'd0, 16'h1001, 32'h0, 1'b1);
    tick();
    idle_in();
    chk("lui_we",    32'(mem_we),   32'd1);
    chk("lui_addr",  32'(mem_addr), 32'd1);
    chk("lui_wdata", mem_wdata,     32'h3C01_1001);
    chk("lui_done",  32'(done),     32'd1);
    chk("lui_count", 32'(count),    32'd2);
    chk("lui_ready", 32'(in_ready), 32'd0);
    tick();
    chk("done_we_off", 32'(mem_we), 32'd0);
    chk("done_hold",   32'(done),   32'd1);

    // SLL rs forced 0, SUB, BEQ at index 2, good J at last index -> full
    do_start();
    cmd(4'd5, 5'd4, 5'd2, 5'd3, 5'd4, 16'h0, 32'h0, 1'b0);
    tick();
    chk("sll_wdata", mem_wdata, 32'h0002_1900);
    cmd(4'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0, 1'b0);
    tick();
    chk("sub_wdata", mem_wdata, 32'h0022_1822);
    cmd(4'd11, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0005, 32'h0, 1'b0);
    tick();
    chk("beq_addr",  32'(mem_addr), 32'd2);
    chk("beq_wdata", mem_wdata,     exp_beq);
    cmd(4'd13, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h0040_0010, 1'b0);
    tick();
    chk("j_addr",  32'(mem_addr), 32'd3);
    chk("j_wdata", mem_wdata,     32'h0810_0004);
    chk("j_err",   32'(err),      32'd0);
    chk("j_full",  32'(full),     32'd1);
    chk("j_done",  32'(done),     32'd1);
    idle_in();

    // Capacity: five commands with valid held, only four accepted
    do_start();
    chk("cap_full0", 32'(full), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cmd(4'd7, 5'd0, 5'(i), 5'd0, 5'd0, 16'(i), 32'h0, 1'b0);
      tick();
      if (i < 4) begin
        chk($sformatf("cap_we%0d", i),   32'(mem_we),   32'd1);
        chk($sformatf("cap_addr%0d", i), 32'(mem_addr), 32'(i));
        chk($sformatf("cap_data%0d", i), mem_wdata, {6'h08, 5'd0, 5'(i), 16'(i)});
      end else begin
        chk("cap_5th_we", 32'(mem_we), 32'd0);
      end
      if (i == 3) begin
        chk("cap_full",  32'(full),     32'd1);
        chk("cap_done",  32'(done),     32'd1);
        chk("cap_ready", 32'(in_ready), 32'd0);
      end
    end
    chk("cap_count", 32'(count), 32'd4);
    idle_in();

    // Out-of-region J: written and err sticky; reserved kind -> NOP
    do_start();
    chk("err_clr", 32'(err), 32'd0);
    cmd(4'd13, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 32'h1000_0000, 1'b0);
    tick();
    chk("jbad_we",    32'(mem_we), 32'd1);
    chk("jbad_wdata", mem_wdata,   32'h0800_0000);
    chk("jbad_err",   32'(err),    32'd1);
    cmd(4'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0, 1'b0);
    tick();
    chk("err_sticky", 32'(err), 32'd1);
    idle_in();

    do_start();
    cmd(4'd15, 5'd1, 5'd2, 5'd3, 5'd4, 16'hFFFF, 32'hFFFF_FFFF, 1'b0);
    tick();
    chk("rsvd_we",    32'(mem_we), 32'd1);
    chk("rsvd_wdata", mem_wdata,   32'h0000_0000);
    chk("rsvd_err",   32'(err),    32'd1);

    // start in LOAD with a same-cycle accept: write dropped, index back to 0
    cmd(4'd2, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_sess_we",  32'(mem_we), 32'd0);
    chk("rst_sess_cnt", 32'(count),  32'd0);
    cmd(4'd3, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0, 1'b0);
    tick();
    chk("or_addr",  32'(mem_addr), 32'd0);
    chk("or_wdata", mem_wdata,     32'h0022_1825);

    // Async reset mid-stream with valid held
    cmd(4'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_we",    32'(mem_we),   32'd0);
    chk("mid_rst_wdata", mem_wdata,     32'd0);
    chk("mid_rst_addr",  32'(mem_addr), 32'd0);
    chk("mid_rst_cnt",   32'(count),    32'd0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_rst_we",    32'(mem_we),   32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd0);
    tick();
    chk("post_rst_we2", 32'(mem_we), 32'd0);

    // Reload from index 0 after reset: NOR
    idle_in();
    do_start();
    cmd(4'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 32'h0, 1'b1);
    tick();
    idle_in();
    chk("nor_addr",  32'(mem_addr), 32'd0);
    chk("nor_wdata", mem_wdata,     32'h0022_1827);
    chk("nor_done",  32'(done),     32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
# mips_instr_encoder

Program-loader encoder for the MIPS core: accepts a stream of symbolic instruction commands over a valid/ready handshake, encodes each into a 32-bit MIPS word and writes it sequentially into instruction memory. It is the inverse of the opcode decoder in the control path and covers the same instruction set. It sits between the testbench/boot source and the instruction-memory write port, ahead of core start.

## Interface
- ADDR_W, 6: instruction-memory word-address width; capacity is 2^ADDR_W words.
- BASE_ADDR, 32'h0040_0000: byte address of memory word 0, used for J/JAL target checks.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begins a load session at word 0.
- in_valid  in  1  command valid.
- in_ready  out  1  command accepted when in_valid & in_ready.
- in_last  in  1  marks the final command of the session.
- in_kind  in  4  instruction select: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 SLL, 6 SRL, 7 ADDI, 8 ORI, 9 ANDI, 10 LUI, 11 BEQ, 12 BNE, 13 J, 14 JAL, 15 reserved.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
- in_imm  in  16  immediate, or branch operand (see Configuration).
- in_target  in  32  J/JAL byte target address.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  word index written.
- mem_wdata  out  32  encoded instruction.
- done  out  1  session finished.
- full  out  1  memory capacity reached.
- err  out  1  sticky: reserved kind seen or J target outside 256 MB region of BASE_ADDR.
- count  out  ADDR_W+1  words written this session.

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE: in_ready=0. start -> LOAD; index, count, err, full clear.
- LOAD: in_ready=1 unless full. Each accepted command is encoded and registered; index increments by 1 per accept.
- Accept with in_last=1, or accept of the word at index 2^ADDR_W-1 -> DONE. The last case also sets full.
- DONE: in_ready=0, done=1. start -> LOAD with a fresh session; all else ignored.
- start while in LOAD restarts the session at index 0. The write for a same-cycle accept is dropped.
- Encoding:
  - R-type: op 0, funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, NOR 0x27, SLL 0x00, SRL 0x02. shamt is forced to 0 for non-shifts; rs is forced to 0 for shifts.
  - I-type: op ADDI 0x08, ORI 0x0D, ANDI 0x0C, LUI 0x0F (rs=0), BEQ 0x04, BNE 0x05.
  - J-type: op J 0x02, JAL 0x03; field = in_target[27:2].
- Reserved kind: word 0x00000000 (NOP) is written and err is set.
- J target with in_target[31:28] != BASE_ADDR[31:28]: word is still written and err is set.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, full=0, err=0, count=0, state IDLE.
- Latency is 1 cycle. A command accepted at edge N appears with mem_we=1, mem_addr=index and mem_wdata valid during cycle N+1. mem_we deasserts the cycle after if there is no new accept.
- Throughput is 1 word per cycle with in_valid held high.
- done and full assert in the same cycle as the final mem_we. count updates with mem_we.
- Reset mid-session aborts immediately. No partial write is issued after reset deasserts.

## Configuration
- ENC_BRANCH_REL_EN defined: for BEQ/BNE, in_imm is the absolute destination word index. The encoder emits offset = in_imm - (index+1), truncated to 16 bits (two's complement).
- ENC_BRANCH_REL_EN undefined: in_imm is emitted raw as the offset field. No subtractor is synthesized.

## Structure
- Package mips_enc_pkg holds:
  - the kind enum;
  - opcode constants (0x00, 0x02, 0x03, 0x04, 0x05, 0x08, 0x0C, 0x0D, 0x0F), shared with the control decoder;
  - funct constants.
- Sub-module mips_instr_fmt: combinational kind+fields -> 32-bit word plus an illegal flag. The top level owns the FSM, index counter, branch adjust and output registers.

## Test plan
- ADD rd=3, rs=1, rt=2 at index 0 -> cycle after accept: mem_we=1, mem_addr=0, mem_wdata=0x00221820.
- Back-to-back stream ADDI rt=8 rs=0 imm=5, then LUI rt=1 imm=0x1001 (last) -> 0x20080005 at 0, 0x3C011001 at 1; done=1 with the second write; count=2.
- With ENC_BRANCH_REL_EN, BEQ rs=1 rt=2 imm=5 at index 2 -> 0x10220002. Without the macro, the same stimulus -> 0x10220005.
- J in_target=0x00400010 -> 0x08100004, err=0. J in_target=0x10000000 -> word written, err=1.
- ADDR_W=2, five commands with in_valid held -> four writes (indices 0–3), full=1 and done=1 with the 4th write, in_ready=0 from then, 5th command not accepted.
- Assert reset during a stream and release it -> all outputs at reset values, no mem_we. start then reloads from index 0. Kind=15 -> 0x00000000 written, err=1.
